axis_data_unpack: RTL



---
 rtl/axis_data_unpack_if.sv | 27 ++
 rtl/axis_data_unpack.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axis_data_unpack_if.sv
// AXI-Stream host-to-card beat bus carrying packed payload frames.
// The master drives beats; the slave (the unpacker) returns tready.
interface axis_data_unpack_if #(
  parameter int AXIS_DATA_WIDTH = 512
);
  logic [AXIS_DATA_WIDTH-1:0] s_axis_h2c_tdata;
  logic [63:0]                s_axis_h2c_tkeep;
  logic                       s_axis_h2c_tlast;
  logic                       s_axis_h2c_tvalid;
  logic                       s_axis_h2c_tready;

  modport master (
    output s_axis_h2c_tdata,
    output s_axis_h2c_tkeep,
    output s_axis_h2c_tlast,
    output s_axis_h2c_tvalid,
    input  s_axis_h2c_tready
  );

  modport slave (
    input  s_axis_h2c_tdata,
    input  s_axis_h2c_tkeep,
    input  s_axis_h2c_tlast,
    input  s_axis_h2c_tvalid,
    output s_axis_h2c_tready
  );
endinterface

// File: rtl/axis_data_unpack.sv
// Reassembles fixed-length BEATS-beat stream frames into one wide payload word,
// tracking a per-frame sequence byte and flagging length/sequence errors.
module axis_data_unpack #(
  parameter int DATA_WIDTH      = 1928,
  parameter int AXIS_DATA_WIDTH = 512
) (
  input  logic                  s_axis_h2c_aclk,
  input  logic                  s_axis_h2c_aresetn,
  axis_data_unpack_if.slave     s_axis,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [7:0]            seq_num,
  output logic                  seq_err,
  output logic                  len_err,
  output logic [1:0]            sstate
);

  localparam int AW      = AXIS_DATA_WIDTH;
  localparam int BEATS   = (DATA_WIDTH + 8 + AW - 1) / AW;
  localparam int FRAME_W = BEATS * AW;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic [7:0]              exp_seq_q;
  logic                    tready_q;
  logic                    data_valid_q;
  logic                    seq_err_q;
  logic                    len_err_q;
  logic [7:0]              seq_num_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [FRAME_W-1:0]      asm_q;

  logic                    hs_w;
  logic                    last_beat_w;
  logic                    slot_free_w;
  logic                    load_w;
  logic [FRAME_W-1:0]      frame_w;
  logic [FRAME_W-1:0]      load_src_w;
  logic [7:0]              load_seq_w;
  logic                    unused_w;

  assign hs_w        = s_axis.s_axis_h2c_tvalid && tready_q;
  assign last_beat_w = (beat_cnt_q == LAST_CNT);
  assign slot_free_w = !data_valid_q || data_ready;

  // The final beat is still on the bus at completion, so splice it in for a
  // same-edge load; in HOLD every beat is already in the assembly register.
  always_comb begin
    frame_w                        = asm_q;
    frame_w[(BEATS-1)*AW +: AW]    = s_axis.s_axis_h2c_tdata;
    load_src_w                     = (state_q == HOLD) ? asm_q : frame_w;
  end

  assign load_seq_w = load_src_w[7:0];
  assign load_w = ((state_q == COLLECT) && hs_w && last_beat_w &&
                   s_axis.s_axis_h2c_tlast && slot_free_w) ||
                  ((state_q == HOLD) && data_ready);

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (state_q == COLLECT && hs_w) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt_q == CNT_W'(k)) asm_q[k*AW +: AW] <= s_axis.s_axis_h2c_tdata;
      end
    end
  end

  always_ff @(posedge s_axis_h2c_aclk) begin
    if (!s_axis_h2c_aresetn) begin
      state_q      <= COLLECT;
      beat_cnt_q   <= '0;
      exp_seq_q    <= 8'd0;
      tready_q     <= 1'b1;
      data_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      seq_num_q    <= 8'd0;
      data_q       <= '0;
    end else begin
      seq_err_q <= 1'b0;
      len_err_q <= 1'b0;
      if (data_valid_q && data_ready) data_valid_q <= 1'b0;

      if (load_w) begin
        data_q       <= load_src_w[8 +: DATA_WIDTH];
        seq_num_q    <= load_seq_w;
        data_valid_q <= 1'b1;
        seq_err_q    <= (load_seq_w != exp_seq_q);
        exp_seq_q    <= load_seq_w + 8'd1;
      end

      case (state_q)
        COLLECT: begin
          if (hs_w) begin
            if (last_beat_w) begin
              beat_cnt_q <= '0;
              if (!s_axis.s_axis_h2c_tlast) begin
                len_err_q <= 1'b1;
                state_q   <= DROP;
              end else if (!slot_free_w) begin
                state_q  <= HOLD;
                tready_q <= 1'b0;
              end
            end else if (s_axis.s_axis_h2c_tlast) begin
              len_err_q  <= 1'b1;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (data_ready) begin
            state_q  <= COLLECT;
            tready_q <= 1'b1;
          end
        end
        DROP: begin
          if (hs_w && s_axis.s_axis_h2c_tlast) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= COLLECT;
          beat_cnt_q <= '0;
          tready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign unused_w = ^{s_axis.s_axis_h2c_tkeep, load_src_w};

  assign s_axis.s_axis_h2c_tready = tready_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign seq_num    = seq_num_q;
  assign seq_err    = seq_err_q;
  assign len_err    = len_err_q;
  assign sstate     = state_q;

endmodule
